lsu_controller: RTL and testbench

Multi-cycle load/store sequencer between the control unit and the 64-bit data memory. It issues aligned doubleword reads and writes and performs read-modify-write for sub-doubleword stores. For loads it sequences the external load-extension unit by driving its select code and operand, then registers the result. Each request gets exactly one response or one misalignment pulse.

---
 rtl/lsu_controller.sv | 213 +++++++++++++++++++++
 tb/tb_lsu_controller.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_controller.sv
// Load/store sequencer for a 64-bit data memory: aligned doubleword access,
// read-modify-write for narrow stores and load extension through an external unit.
module lsu_controller #(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic [63:0] mem_addr,
    output logic        mem_wr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata,
    output logic [4:0]  ext_sel,
    output logic [63:0] ext_in,
    input  logic [63:0] ext_out,
    output logic        resp_valid,
    output logic [63:0] resp_data,
    output logic        misaligned
);

    // state | meaning
    // IDLE  | waiting for a request, req_ready high
    // READ  | memory read in flight, MEM_LAT cycles
    // EXT   | extension unit driven, result registered
    // MERGE | store bytes merged into the read doubleword
    // WRITE | one-cycle write strobe
    // RESP  | one-cycle completion pulse
    // ERR   | one-cycle misalignment pulse
    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_EXT, S_MERGE, S_WRITE, S_RESP, S_ERR
    } state_t;

    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          store_q, store_d;
    logic [1:0]    size_q, size_d;
    logic          uns_q, uns_d;
    logic [2:0]    off_q, off_d;
    logic [63:0]   wdata_q, wdata_d;
    logic [63:0]   rbuf_q, rbuf_d;
    logic [63:0]   mem_addr_q, mem_addr_d;
    logic          mem_wr_q, mem_wr_d;
    logic [63:0]   mem_wdata_q, mem_wdata_d;
    logic [4:0]    ext_sel_q, ext_sel_d;
    logic [63:0]   ext_in_q, ext_in_d;
    logic          resp_valid_q, resp_valid_d;
    logic [63:0]   resp_data_q, resp_data_d;
    logic          misaligned_q, misaligned_d;
    logic          req_ready_q, req_ready_d;

    logic          req_mis;
    logic [63:0]   lane_mask;
    logic [63:0]   wbuf;

    always_comb begin
        req_mis = 1'b0;
        case (req_size)
            2'd0:    req_mis = 1'b0;
            2'd1:    req_mis = req_addr[0];
            2'd2:    req_mis = |req_addr[1:0];
            default: req_mis = |req_addr[2:0];
        endcase
    end

    always_comb begin
        lane_mask = 64'h0000_0000_FFFF_FFFF;
        case (size_q)
            2'd0:    lane_mask = 64'h0000_0000_0000_00FF;
            2'd1:    lane_mask = 64'h0000_0000_0000_FFFF;
            default: lane_mask = 64'h0000_0000_FFFF_FFFF;
        endcase
        wbuf = (rbuf_q & ~(lane_mask << {off_q, 3'b000}))
             | ((wdata_q & lane_mask) << {off_q, 3'b000});
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        store_d      = store_q;
        size_d       = size_q;
        uns_d        = uns_q;
        off_d        = off_q;
        wdata_d      = wdata_q;
        rbuf_d       = rbuf_q;
        mem_addr_d   = mem_addr_q;
        mem_wr_d     = 1'b0;
        mem_wdata_d  = mem_wdata_q;
        ext_sel_d    = 5'd0;
        ext_in_d     = 64'h0;
        resp_valid_d = 1'b0;
        resp_data_d  = resp_data_q;
        misaligned_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    store_d     = req_store;
                    size_d      = req_size;
                    uns_d       = req_unsigned;
                    off_d       = req_addr[2:0];
                    wdata_d     = req_wdata;
                    mem_addr_d  = {req_addr[63:3], 3'b000};
                    resp_data_d = 64'h0;
                    if (req_mis) begin
                        state_d      = S_ERR;
                        misaligned_d = 1'b1;
                    end else if (req_store && req_size == 2'd3) begin
                        state_d     = S_WRITE;
                        mem_wr_d    = 1'b1;
                        mem_wdata_d = req_wdata;
                    end else begin
                        state_d = S_READ;
                        cnt_d   = CW'(MEM_LAT - 1);
                    end
                end
            end
            S_READ: begin
                if (cnt_q == '0) begin
                    rbuf_d = mem_rdata;
                    if (store_q) begin
                        state_d = S_MERGE;
                    end else begin
                        // Extension operands are registered so they are stable for the whole EXT cycle.
                        state_d   = S_EXT;
                        ext_in_d  = mem_rdata >> {off_q, 3'b000};
                        ext_sel_d = (size_q == 2'd3) ? 5'd0
                                  : ({3'b000, size_q} + (uns_q ? 5'd3 : 5'd0));
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_EXT: begin
                resp_data_d  = (size_q == 2'd3) ? rbuf_q : ext_out;
                resp_valid_d = 1'b1;
                state_d      = S_RESP;
            end
            S_MERGE: begin
                mem_wdata_d = wbuf;
                mem_wr_d    = 1'b1;
                state_d     = S_WRITE;
            end
            S_WRITE: begin
                resp_valid_d = 1'b1;
                state_d      = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        req_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            store_q      <= 1'b0;
            size_q       <= 2'd0;
            uns_q        <= 1'b0;
            off_q        <= 3'd0;
            wdata_q      <= 64'h0;
            rbuf_q       <= 64'h0;
            mem_addr_q   <= 64'h0;
            mem_wr_q     <= 1'b0;
            mem_wdata_q  <= 64'h0;
            ext_sel_q    <= 5'd0;
            ext_in_q     <= 64'h0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= 64'h0;
            misaligned_q <= 1'b0;
            req_ready_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            store_q      <= store_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            off_q        <= off_d;
            wdata_q      <= wdata_d;
            rbuf_q       <= rbuf_d;
            mem_addr_q   <= mem_addr_d;
            mem_wr_q     <= mem_wr_d;
            mem_wdata_q  <= mem_wdata_d;
            ext_sel_q    <= ext_sel_d;
            ext_in_q     <= ext_in_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            misaligned_q <= misaligned_d;
            req_ready_q  <= req_ready_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wr     = mem_wr_q;
    assign mem_wdata  = mem_wdata_q;
    assign ext_sel    = ext_sel_q;
    assign ext_in     = ext_in_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign misaligned = misaligned_q;

endmodule

// File: tb/tb_lsu_controller.sv
// Bench for lsu_controller: memory and extension-unit models, directed plan steps
// and randomized requests checked against a byte-level reference model.
module tb_lsu_controller;
    localparam int MEM_LAT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [63:0] req_addr = 64'h0;
    logic [63:0] req_wdata = 64'h0;
    logic [63:0] mem_addr;
    logic        mem_wr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata = 64'h0;
    logic [4:0]  ext_sel;
    logic [63:0] ext_in;
    logic [63:0] ext_out;
    logic        resp_valid;
    logic [63:0] resp_data;
    logic        misaligned;

    int checks = 0;
    int errors = 0;

    logic [63:0] mem [logic [63:0]];
    logic        pl_valid = 1'b0;
    logic [63:0] pl_addr = 64'h0;
    logic [63:0] pl_data = 64'h0;

    lsu_controller #(.MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .mem_addr(mem_addr), .mem_wr(mem_wr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .ext_sel(ext_sel),
        .ext_in(ext_in), .ext_out(ext_out), .resp_valid(resp_valid),
        .resp_data(resp_data), .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mem_rd(input logic [63:0] a);
        if (mem.exists(a)) return mem[a];
        return 64'h0;
    endfunction

    // Memory lives mid-cycle so it never races the DUT's registered outputs.
    always @(negedge clk) begin
        if (pl_valid) mem[pl_addr] = pl_data;
        if (mem_wr) mem[mem_addr] = mem_wdata;
        mem_rdata = mem_rd(mem_addr);
    end

    always_comb begin
        ext_out = 64'h0;
        case (ext_sel)
            5'd0: ext_out = {{56{ext_in[7]}}, ext_in[7:0]};
            5'd1: ext_out = {{48{ext_in[15]}}, ext_in[15:0]};
            5'd2: ext_out = {{32{ext_in[31]}}, ext_in[31:0]};
            5'd3: ext_out = {56'h0, ext_in[7:0]};
            5'd4: ext_out = {48'h0, ext_in[15:0]};
            5'd5: ext_out = {32'h0, ext_in[31:0]};
            default: ext_out = 64'h0;
        endcase
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [63:0] a, input logic [63:0] d);
        pl_addr  = a;
        pl_data  = d;
        pl_valid = 1'b1;
        @(negedge clk);
        #1;
        pl_valid = 1'b0;
    endtask

    function automatic logic [63:0] ref_load(input logic [63:0] dw, input int off,
                                             input int sz, input bit uns);
        logic [63:0] v, m;
        int nb;
        if (sz == 3) return dw;
        nb = 1 << sz;
        v  = dw >> (8 * off);
        m  = (64'd1 << (8 * nb)) - 64'd1;
        v  = v & m;
        if (!uns && v[8 * nb - 1]) v = v | ~m;
        return v;
    endfunction

    function automatic logic [63:0] ref_store(input logic [63:0] dw, input int off,
                                              input int sz, input logic [63:0] wd);
        logic [63:0] r;
        r = dw;
        if (sz == 3) return wd;
        for (int i = 0; i < (1 << sz); i++) r[8 * (off + i) +: 8] = wd[8 * i +: 8];
        return r;
    endfunction

    // Issues one request from post-edge time and watches a fixed window of cycles.
    task automatic do_req(input bit st, input int sz, input bit un,
                          input logic [63:0] ad, input logic [63:0] wd,
                          output logic [63:0] got);
        logic [63:0] base, dw, exp_data, exp_wr, resp_val, wr_val;
        int off, exp_resp, exp_wr_k, exp_ext, last;
        int resp_k, wr_k, mis_k, n_resp, n_wr, n_mis;
        bit mis, addr_bad, sel_bad;

        base = {ad[63:3], 3'b000};
        off  = int'(ad[2:0]);
        dw   = mem_rd(base);
        mis  = (off % (1 << sz)) != 0;
        exp_ext = -1; exp_wr_k = -1; exp_resp = -1;
        if (mis) begin
            last = 1;
        end else if (st && sz == 3) begin
            exp_wr_k = 1; exp_resp = 2;
        end else if (st) begin
            exp_wr_k = MEM_LAT + 2; exp_resp = MEM_LAT + 3;
        end else begin
            exp_ext = MEM_LAT + 1; exp_resp = MEM_LAT + 2;
        end
        if (!mis) last = exp_resp;
        exp_data = st ? 64'h0 : ref_load(dw, off, sz, un);
        exp_wr   = ref_store(dw, off, sz, wd);

        check("ready_before", {63'h0, req_ready}, 64'd1);
        req_valid = 1'b1; req_store = st; req_size = 2'(sz);
        req_unsigned = un; req_addr = ad; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_store = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
        req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};

        resp_k = -1; wr_k = -1; mis_k = -1; n_resp = 0; n_wr = 0; n_mis = 0;
        resp_val = 64'h0; wr_val = 64'h0; addr_bad = 1'b0; sel_bad = 1'b0;
        for (int k = 1; k <= MEM_LAT + 6; k++) begin
            if (k > 1) begin @(posedge clk); #1; end
            if (mem_addr !== base) addr_bad = 1'b1;
            if (mem_wr) begin n_wr++; if (wr_k < 0) begin wr_k = k; wr_val = mem_wdata; end end
            if (resp_valid) begin n_resp++; if (resp_k < 0) begin resp_k = k; resp_val = resp_data; end end
            if (misaligned) begin n_mis++; if (mis_k < 0) mis_k = k; end
            if (k == exp_ext) begin
                check("ext_sel", {59'h0, ext_sel}, (sz == 3) ? 64'd0 : 64'(sz + 3 * un));
                check("ext_in", ext_in, dw >> (8 * off));
            end else if (ext_sel !== 5'd0) begin
                sel_bad = 1'b1;
            end
            if (k == 1) check("ready_busy", {63'h0, req_ready}, 64'd0);
            if (k == last + 1) begin
                check("ready_after", {63'h0, req_ready}, 64'd1);
                if (!mis) check("resp_hold", resp_data, exp_data);
            end
        end

        check("mem_addr_held", {63'h0, addr_bad}, 64'd0);
        check("ext_sel_idle", {63'h0, sel_bad}, 64'd0);
        check("wr_count", 64'(n_wr), (exp_wr_k > 0) ? 64'd1 : 64'd0);
        check("wr_cycle", 64'(wr_k), 64'(exp_wr_k));
        if (exp_wr_k > 0) check("wr_data", wr_val, exp_wr);
        check("resp_count", 64'(n_resp), (exp_resp > 0) ? 64'd1 : 64'd0);
        check("resp_cycle", 64'(resp_k), 64'(exp_resp));
        if (exp_resp > 0) check("resp_data", resp_val, exp_data);
        check("mis_count", 64'(n_mis), mis ? 64'd1 : 64'd0);
        check("mis_cycle", 64'(mis_k), mis ? 64'd1 : -64'sd1);
        got = resp_val;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ready"}, {63'h0, req_ready}, 64'd1);
        check({tag, "_addr"}, mem_addr, 64'h0);
        check({tag, "_wr"}, {63'h0, mem_wr}, 64'd0);
        check({tag, "_wdata"}, mem_wdata, 64'h0);
        check({tag, "_sel"}, {59'h0, ext_sel}, 64'd0);
        check({tag, "_ext_in"}, ext_in, 64'h0);
        check({tag, "_resp"}, {63'h0, resp_valid}, 64'd0);
        check({tag, "_rdata"}, resp_data, 64'h0);
        check({tag, "_mis"}, {63'h0, misaligned}, 64'd0);
    endtask

    initial begin
        logic [63:0] got;
        bit stray;

        preload(64'h1000, 64'h1122_3344_8566_7788);
        preload(64'h2000, 64'h8000_0001_0000_0000);
        preload(64'h3000, 64'h1111_2222_3333_4444);
        preload(64'h5008, 64'h0123_4567_89AB_CDEF);
        preload(64'h6000, 64'hA5A5_A5A5_A5A5_A5A5);
        for (int i = 0; i < 8; i++) preload(64'h8000 + 64'(8 * i), {$urandom, $urandom});
        @(posedge clk);
        #1;
        check_idle_outputs("reset");
        reset = 1'b0;
        @(posedge clk);
        #1;

        do_req(1'b0, 0, 1'b0, 64'h1003, 64'h0, got);
        check("tp_lb", got, 64'hFFFF_FFFF_FFFF_FF85);
        do_req(1'b0, 0, 1'b1, 64'h1003, 64'h0, got);
        check("tp_lbu", got, 64'h0000_0000_0000_0085);
        do_req(1'b0, 2, 1'b0, 64'h2004, 64'h0, got);
        check("tp_lw", got, 64'hFFFF_FFFF_8000_0001);
        do_req(1'b0, 2, 1'b1, 64'h2004, 64'h0, got);
        check("tp_lwu", got, 64'h0000_0000_8000_0001);
        do_req(1'b0, 3, 1'b0, 64'h2000, 64'h0, got);
        check("tp_ld", got, 64'h8000_0001_0000_0000);
        do_req(1'b1, 1, 1'b0, 64'h3002, 64'hFFFF_ABCD, got);
        check("tp_sh_mem", mem_rd(64'h3000), 64'h1111_2222_ABCD_4444);
        do_req(1'b1, 3, 1'b0, 64'h4000, 64'hDEAD_BEEF_CAFE_F00D, got);
        check("tp_sd_mem", mem_rd(64'h4000), 64'hDEAD_BEEF_CAFE_F00D);
        do_req(1'b0, 1, 1'b0, 64'h5001, 64'h0, got);
        do_req(1'b0, 3, 1'b0, 64'h5008, 64'h0, got);
        check("tp_ld_after_err", got, 64'h0123_4567_89AB_CDEF);

        // Reset lands while the byte store sits in MERGE.
        req_valid = 1'b1; req_store = 1'b1; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 64'h6005; req_wdata = 64'h0000_0000_0000_003C;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (MEM_LAT) begin @(posedge clk); #1; end
        check("rst_merge_wr", {63'h0, mem_wr}, 64'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_idle_outputs("rst_mid");
        stray = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (mem_wr || resp_valid || misaligned) stray = 1'b1;
        end
        check("rst_no_stray", {63'h0, stray}, 64'd0);
        check("rst_mem_kept", mem_rd(64'h6000), 64'hA5A5_A5A5_A5A5_A5A5);

        // Reset and a request in the same cycle: the request must be dropped.
        reset = 1'b1; req_valid = 1'b1; req_store = 1'b0; req_size = 2'd3; req_addr = 64'h7000;
        @(posedge clk);
        #1;
        reset = 1'b0; req_valid = 1'b0;
        check_idle_outputs("rst_req");
        @(posedge clk);
        #1;
        check("rst_req_ready2", {63'h0, req_ready}, 64'd1);

        for (int n = 0; n < 60; n++) begin
            do_req(1'($urandom), int'($urandom_range(0, 3)), 1'($urandom),
                   64'h8000 + 64'(8 * $urandom_range(0, 7)) + 64'($urandom_range(0, 7)),
                   {$urandom, $urandom}, got);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
